// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver and its transmit successor:
// state encoding, parity modes and the data-width offset.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_t;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    // dataBits encodes the word length minus this offset (00 = 5 bits).
    localparam int DATA_BITS_OFFSET = 5;

    // Mode 2'b11 is reserved and behaves as "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period delay counter: restart clears it, o_half/o_full flag the clock on which
// the incremented count reaches P/2 or P.
module uart_bit_timer #(
    parameter int CLOCK_SCALE_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_restart,
    input  logic [CLOCK_SCALE_BITS-1:0] i_period,
    output logic                        o_half,
    output logic                        o_full
);

    localparam logic [CLOCK_SCALE_BITS-1:0] ONE = 1;

    logic [CLOCK_SCALE_BITS-1:0] r_count;
    logic [CLOCK_SCALE_BITS-1:0] w_next;

    assign w_next = r_count + ONE;

    // Greater-or-equal keeps degenerate periods (0..3) from ever waiting for a wrap.
    assign o_half = (w_next >= (i_period >> 1));
    assign o_full = (w_next >= i_period);

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/uart_rx_config.sv
// Runtime-configurable UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop bits).
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three clocks.
module uart_rx_config
    import uart_pkg::*;
#(
    parameter int CLOCK_SCALE_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic [1:0]                  dataBits,
    input  logic [1:0]                  parityMode,
    input  logic                        stopBits,
    input  logic                        rx,
    output logic [7:0]                  dataOut,
    output logic                        dataAvailable,
    output logic                        parityError,
    output logic                        framingError,
    output logic                        breakDetect,
    output logic                        busy
);

    uart_state_t                 r_state;
    logic [CLOCK_SCALE_BITS-1:0] r_period;
    logic [1:0]                  r_nbits_m5;
    logic [1:0]                  r_parity_mode;
    logic                        r_two_stop;
    logic [7:0]                  r_shift;
    logic [2:0]                  r_bit_cnt;
    logic                        r_stop_idx;
    logic                        r_par_acc;
    logic                        r_par_err;
    logic                        r_all_zero;
    logic [7:0]                  r_data_out;
    logic                        r_data_avail;
    logic                        r_parity_error;
    logic                        r_framing_error;
    logic                        r_break;

    logic       w_sample;
    logic       w_sample_evt;
    logic       w_restart;
    logic       w_half;
    logic       w_full;
    logic [3:0] w_nbits;
    logic       w_last_data;
    logic       w_par_expected;
    logic [7:0] w_data_aligned;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_rx_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_hist <= 2'b11;
        end else begin
            r_rx_hist <= {r_rx_hist[0], rx};
        end
    end

    // Vote over rx at the sample clock and the two clocks before it.
    assign w_sample = (rx & r_rx_hist[0]) | (rx & r_rx_hist[1]) | (r_rx_hist[0] & r_rx_hist[1]);
`else
    assign w_sample = rx;
`endif

    // NOTE: combinational outputs get a default before the case so no path infers a latch.
    always_comb begin
        w_sample_evt = 1'b0;
        case (r_state)
            START:              w_sample_evt = w_half;
            DATA, PARITY, STOP: w_sample_evt = w_full;
            default:            w_sample_evt = 1'b0;
        endcase
    end

    // The counter sits at zero while idle or waiting, and restarts on every sample.
    assign w_restart = (r_state == IDLE) || (r_state == WAIT_HIGH) || w_sample_evt;

    uart_bit_timer #(
        .CLOCK_SCALE_BITS(CLOCK_SCALE_BITS)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .i_period  (r_period),
        .o_half    (w_half),
        .o_full    (w_full)
    );

    assign w_nbits        = {2'b00, r_nbits_m5} + 4'(DATA_BITS_OFFSET);
    assign w_last_data    = (r_bit_cnt == 3'(w_nbits - 4'd1));
    assign w_par_expected = (r_parity_mode == PARITY_ODD) ? ~r_par_acc : r_par_acc;
    // Bits enter at the MSB, so a short word sits in the top of r_shift.
    assign w_data_aligned = r_shift >> (4'd8 - w_nbits);

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_period        <= '0;
            r_nbits_m5      <= '0;
            r_parity_mode   <= PARITY_NONE;
            r_two_stop      <= 1'b0;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_stop_idx      <= 1'b0;
            r_par_acc       <= 1'b0;
            r_par_err       <= 1'b0;
            r_all_zero      <= 1'b0;
            r_data_out      <= '0;
            r_data_avail    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_break         <= 1'b0;
        end else begin
            r_data_avail <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bit_cnt  <= '0;
                    r_stop_idx <= 1'b0;
                    if (enable && !rx) begin
                        r_period      <= cyclesPerBit;
                        r_nbits_m5    <= dataBits;
                        r_parity_mode <= parityMode;
                        r_two_stop    <= stopBits;
                        r_state       <= START;
                    end
                end
                START: begin
                    if (w_half) begin
                        if (w_sample) begin
                            r_state <= IDLE;
                        end else begin
                            r_shift    <= '0;
                            r_par_acc  <= 1'b0;
                            r_par_err  <= 1'b0;
                            r_all_zero <= 1'b1;
                            r_state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_full) begin
                        r_shift    <= {w_sample, r_shift[7:1]};
                        r_par_acc  <= r_par_acc ^ w_sample;
                        r_all_zero <= r_all_zero & ~w_sample;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (w_last_data) begin
                            r_state <= parity_enabled(r_parity_mode) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_full) begin
                        r_par_err  <= (w_sample != w_par_expected);
                        r_all_zero <= r_all_zero & ~w_sample;
                        r_state    <= STOP;
                    end
                end
                STOP: begin
                    if (w_full) begin
                        // A low stop bit ends the frame at once; a high first stop waits for the second.
                        if (!w_sample || !r_two_stop || r_stop_idx) begin
                            r_data_avail    <= 1'b1;
                            r_data_out      <= w_data_aligned;
                            r_parity_error  <= r_par_err;
                            r_framing_error <= ~w_sample;
                            r_break         <= ~w_sample & ~r_stop_idx & r_all_zero;
                            r_state         <= w_sample ? IDLE : WAIT_HIGH;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dataOut       = r_data_out;
    assign dataAvailable = r_data_avail;
    assign parityError   = r_parity_error;
    assign framingError  = r_framing_error;
    assign breakDetect   = r_break;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_config.sv
// Self-checking bench for uart_rx_config: frames are built bit by bit, expected results are
// queued when a frame is driven and compared against each dataAvailable pulse.
module tb_uart_rx_config;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_EVEN = 2'b01;
    localparam logic [1:0] P_ODD  = 2'b10;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        enable       = 1'b0;
    logic [15:0] cyclesPerBit = 16'd16;
    logic [1:0]  dataBits     = 2'd3;
    logic [1:0]  parityMode   = 2'd0;
    logic        stopBits     = 1'b0;
    logic        rx           = 1'b1;
    logic [7:0]  dataOut;
    logic        dataAvailable;
    logic        parityError;
    logic        framingError;
    logic        breakDetect;
    logic        busy;

    uart_rx_config #(
        .CLOCK_SCALE_BITS(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .cyclesPerBit  (cyclesPerBit),
        .dataBits      (dataBits),
        .parityMode    (parityMode),
        .stopBits      (stopBits),
        .rx            (rx),
        .dataOut       (dataOut),
        .dataAvailable (dataAvailable),
        .parityError   (parityError),
        .framingError  (framingError),
        .breakDetect   (breakDetect),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       bsy;
        int         cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];
    rec_t last;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Advance to the next falling edge; cyc then equals the index of the rising edge just passed.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (dataAvailable) begin
            got_q.push_back('{dataOut, parityError, framingError, breakDetect, busy, cyc});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int p, input logic [1:0] db, input logic [1:0] pm, input logic sb);
        cyclesPerBit = 16'(p);
        dataBits     = db;
        parityMode   = pm;
        stopBits     = sb;
    endtask

    function automatic int build(input logic [7:0] d, input int n, input logic par_en,
                                 input logic par_bit, input int nstop, input logic s2,
                                 output logic [15:0] bits);
        int k;
        bits    = '1;
        bits[0] = 1'b0;
        k       = 1;
        for (int i = 0; i < n; i++) begin
            bits[k] = d[i];
            k++;
        end
        if (par_en) begin
            bits[k] = par_bit;
            k++;
        end
        bits[k] = 1'b1;
        k++;
        if (nstop == 2) begin
            bits[k] = s2;
            k++;
        end
        return k;
    endfunction

    // Each bit lasts p clocks; the value driven now is seen by the next rising edge.
    task automatic send(input logic [15:0] bits, input int len, input int p, input int max_ticks,
                        input int gbit, input int goff, input int mess_at);
        int t;
        t = 0;
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < p; c++) begin
                if (max_ticks >= 0 && t >= max_ticks) return;
                if (t == mess_at) set_cfg(16, 2'd3, P_NONE, 1'b1);
                rx = bits[b] ^ ((b == gbit) && (c == goff));
                tick();
                t++;
            end
        end
    endtask

    task automatic sb_drain(input string name);
        rec_t e;
        rec_t g;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s pulse count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e    = exp_q.pop_front();
            g    = got_q.pop_front();
            last = e;
            checks++;
            if (g.data !== e.data) begin
                errors++;
                $display("FAIL %s dataOut: got %02h expected %02h", name, g.data, e.data);
            end
            checks++;
            if ({g.perr, g.ferr, g.brk} !== {e.perr, e.ferr, e.brk}) begin
                errors++;
                $display("FAIL %s flags p/f/b: got %b%b%b expected %b%b%b", name,
                         g.perr, g.ferr, g.brk, e.perr, e.ferr, e.brk);
            end
            checks++;
            if (g.bsy !== e.bsy) begin
                errors++;
                $display("FAIL %s busy at pulse: got %b expected %b", name, g.bsy, e.bsy);
            end
            checks++;
            if (g.cyc != e.cyc) begin
                errors++;
                $display("FAIL %s pulse edge: got %0d expected %0d", name, g.cyc, e.cyc);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (dataOut !== 8'h00)      begin errors++; $display("FAIL reset dataOut: got %02h expected 00", dataOut); end
        checks++; if (dataAvailable !== 1'b0) begin errors++; $display("FAIL reset dataAvailable: got %b expected 0", dataAvailable); end
        checks++; if ({parityError, framingError, breakDetect} !== 3'b000) begin
            errors++; $display("FAIL reset flags: got %b%b%b expected 000", parityError, framingError, breakDetect);
        end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        rst    = 1'b0;
        enable = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL idle busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_8n1();
        logic [15:0] bits;
        int len, c0;
        set_cfg(16, 2'd3, P_NONE, 1'b0);
        len = build(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, bits);
        c0  = cyc;
        exp_q.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, c0 + 1 + 8 + (len - 1) * 16});
        send(bits, len, 16, -1, -1, 0, -1);
        rx = 1'b1;
        idle(4);
        sb_drain("basic_8n1");
    endtask

    task automatic test_parity_7e1();
        logic [15:0] bits;
        logic [7:0] d;
        int len, c0;
        d = 8'h41;
        for (int pb = 1; pb >= 0; pb--) begin
            set_cfg(16, 2'd2, P_EVEN, 1'b0);
            len = build(d, 7, 1'b1, 1'(pb), 1, 1'b1, bits);
            c0  = cyc;
            exp_q.push_back('{d, 1'(pb) ^ (^(d & 8'h7F)), 1'b0, 1'b0, 1'b0, c0 + 1 + 8 + (len - 1) * 16});
            send(bits, len, 16, -1, -1, 0, -1);
            rx = 1'b1;
            idle(4);
            sb_drain("parity_7e1");
        end
    endtask

    // 5O1 at the minimum bit period, with the config inputs scrambled once the frame has started.
    task automatic test_config_latch();
        logic [15:0] bits;
        logic [7:0] d;
        int len, c0;
        d = 8'h15;
        for (int pb = 0; pb <= 1; pb++) begin
            set_cfg(4, 2'd0, P_ODD, 1'b0);
            len = build(d, 5, 1'b1, 1'(pb), 1, 1'b1, bits);
            c0  = cyc;
            exp_q.push_back('{d, 1'(pb) ^ ~(^(d & 8'h1F)), 1'b0, 1'b0, 1'b0, c0 + 1 + 2 + (len - 1) * 4});
            send(bits, len, 4, -1, -1, 0, 3);
            rx = 1'b1;
            idle(6);
            sb_drain("config_latch");
        end
    endtask

    task automatic test_start_glitch();
        set_cfg(16, 2'd3, P_NONE, 1'b0);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch pulses: got %0d expected 0", got_q.size()); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL glitch busy: got %b expected 0", busy); end
        checks++; if (dataOut !== last.data) begin errors++; $display("FAIL glitch dataOut: got %02h expected %02h", dataOut, last.data); end
        checks++; if ({parityError, framingError, breakDetect} !== {last.perr, last.ferr, last.brk}) begin
            errors++; $display("FAIL glitch flags: got %b%b%b expected %b%b%b", parityError, framingError,
                               breakDetect, last.perr, last.ferr, last.brk);
        end
        got_q.delete();
    endtask

    task automatic test_two_stop_framing();
        logic [15:0] bits;
        int len, c0;
        set_cfg(16, 2'd3, P_NONE, 1'b1);
        len = build(8'hA5, 8, 1'b0, 1'b0, 2, 1'b0, bits);
        c0  = cyc;
        exp_q.push_back('{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, c0 + 1 + 8 + (len - 1) * 16});
        send(bits, len, 16, -1, -1, 0, -1);
        idle(48);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL 8n2 wait_high busy: got %b expected 1", busy); end
        rx = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 8n2 released busy: got %b expected 0", busy); end
        sb_drain("two_stop_framing");
    endtask

    task automatic test_break();
        int c0;
        set_cfg(16, 2'd3, P_NONE, 1'b0);
        c0 = cyc;
        exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, c0 + 1 + 8 + 9 * 16});
        send(16'h0000, 12, 16, -1, -1, 0, -1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break held busy: got %b expected 1", busy); end
        rx = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break released busy: got %b expected 0", busy); end
        sb_drain("break");
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits;
        int len, c0;
        set_cfg(16, 2'd3, P_NONE, 1'b0);
        len = build(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, bits);
        send(bits, len, 16, 5 * 16, -1, 0, -1);
        rst = 1'b1;
        tick();
        checks++; if (dataOut !== 8'h00)      begin errors++; $display("FAIL midreset dataOut: got %02h expected 00", dataOut); end
        checks++; if (dataAvailable !== 1'b0) begin errors++; $display("FAIL midreset dataAvailable: got %b expected 0", dataAvailable); end
        checks++; if ({parityError, framingError, breakDetect} !== 3'b000) begin
            errors++; $display("FAIL midreset flags: got %b%b%b expected 000", parityError, framingError, breakDetect);
        end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL midreset busy: got %b expected 0", busy); end
        rst = 1'b0;
        rx  = 1'b1;
        idle(100);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midreset pulses: got %0d expected 0", got_q.size()); end
        got_q.delete();
        c0 = cyc;
        exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, c0 + 1 + 8 + (len - 1) * 16});
        send(bits, len, 16, -1, -1, 0, -1);
        rx = 1'b1;
        idle(4);
        sb_drain("after_reset");
    endtask

    // The second start bit is driven on the clock right after the first frame completes.
    task automatic test_back_to_back();
        logic [15:0] b1;
        logic [15:0] b2;
        int len, c0;
        set_cfg(16, 2'd3, P_NONE, 1'b0);
        len = build(8'h96, 8, 1'b0, 1'b0, 1, 1'b1, b1);
        len = build(8'h69, 8, 1'b0, 1'b0, 1, 1'b1, b2);
        c0  = cyc;
        exp_q.push_back('{8'h96, 1'b0, 1'b0, 1'b0, 1'b0, c0 + 1 + 8 + (len - 1) * 16});
        send(b1, len, 16, (len - 1) * 16 + 8 + 1, -1, 0, -1);
        c0 = cyc;
        exp_q.push_back('{8'h69, 1'b0, 1'b0, 1'b0, 1'b0, c0 + 1 + 8 + (len - 1) * 16});
        send(b2, len, 16, -1, -1, 0, -1);
        rx = 1'b1;
        idle(4);
        sb_drain("back_to_back");
    endtask

    task automatic test_data_glitch();
        logic [15:0] bits;
        logic [7:0] want;
        int len, c0;
`ifdef UART_RX_MAJORITY_EN
        want = 8'h00;
`else
        want = 8'h08;
`endif
        set_cfg(16, 2'd3, P_NONE, 1'b0);
        len = build(8'h00, 8, 1'b0, 1'b0, 1, 1'b1, bits);
        c0  = cyc;
        exp_q.push_back('{want, 1'b0, 1'b0, 1'b0, 1'b0, c0 + 1 + 8 + (len - 1) * 16});
        send(bits, len, 16, -1, 4, 8, -1);
        rx = 1'b1;
        idle(4);
        sb_drain("data_glitch");
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_7e1();
        test_config_latch();
        test_start_glitch();
        test_two_stop_framing();
        test_break();
        test_reset_mid_frame();
        test_back_to_back();
        test_data_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
